// File: rtl/exception_controller.sv
// -----------------------------------------------------------------------------
// exception_controller
//
// Purpose:
//   Turns the registered MEM-stage exception code into pipeline control. When an
//   exception is accepted the controller latches the cause and the faulting PC
//   (EPC), squashes the younger pipeline stages for FLUSH_CYCLES cycles, and then
//   redirects fetch to a per-cause handler vector. An eret from the handler
//   returns to EPC+1. A second exception raised while the handler is running is
//   treated as a double fault, and the core halts until reset.
//
// Ports:
//   clk          in   1      clock; all state updates on the rising edge
//   reset        in   1      synchronous active-low reset (0 = reset)
//   exp_error    in   2      exception code: 00 none, 01 ovf, 10 illegal, 11 mem
//   mem_pc       in   PC_W   PC of the instruction currently in MEM
//   eret         in   1      return-from-exception strobe
//   flush        out  1      squash IF/ID/EX/MEM
//   redirect_en  out  1      one-cycle PC override strobe
//   redirect_pc  out  PC_W   redirect target, valid while redirect_en=1
//   in_handler   out  1      handler is executing
//   halted       out  1      double fault, core stopped
//   cause        out  2      latched exception code
//   epc          out  PC_W   latched faulting PC
//   exp_count    out  CNT_W  accepted exceptions, saturating
// -----------------------------------------------------------------------------
module exception_controller #(
  parameter int              PC_W         = 10,
  parameter logic [PC_W-1:0] VEC_BASE     = 'h3C0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       exp_error,
  input  logic [PC_W-1:0]  mem_pc,
  input  logic             eret,
  output logic             flush,
  output logic             redirect_en,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             in_handler,
  output logic             halted,
  output logic [1:0]       cause,
  output logic [PC_W-1:0]  epc,
  output logic [CNT_W-1:0] exp_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [PC_W-1:0]  epc_q, epc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;

  // The counter stays stuck at all-ones once it gets there.
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      cause_q     <= '0;
      epc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    count_d     = count_q;
    case (state_q)
      ST_IDLE: begin
        if (exp_error != 2'b00) begin
          cause_d     = exp_error;
          epc_d       = mem_pc;
          count_d     = count_inc;
          // The first flush cycle is the one right after acceptance, so the
          // counter is loaded with one less than the total flush length.
          flush_cnt_d = 4'(FLUSH_CYCLES - 1);
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Incoming codes are from instructions being squashed and are dropped.
        if (flush_cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler takes priority over a concurrent eret.
        // cause/epc stay frozen so they still describe the original fault.
        if (exp_error != 2'b00) begin
          count_d = count_inc;
          state_d = ST_HALTED;
        end else if (eret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded purely from registered state so no input reaches an
  // output combinationally.
  always_comb begin
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    in_handler  = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        flush = 1'b1;
      end
      ST_REDIRECT: begin
        redirect_en = 1'b1;
        redirect_pc = VEC_BASE + PC_W'({cause_q, 2'b00});
      end
      ST_HANDLER: begin
        in_handler = 1'b1;
      end
      ST_RETURN: begin
        // Resume after the faulting instruction; handler-side fetches are squashed.
        flush       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = epc_q + PC_W'(1);
      end
      ST_HALTED: begin
        flush  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        flush = 1'b0;
      end
    endcase
  end

  assign cause     = cause_q;
  assign epc       = epc_q;
  assign exp_count = count_q;

endmodule

// File: tb/tb_exception_controller.sv
// -----------------------------------------------------------------------------
// tb_exception_controller
//
// Purpose:
//   Self-checking bench for exception_controller. A reference model describes
//   the controller as a script of expected per-cycle outputs: accepting an
//   exception queues FLUSH_CYCLES flush cycles plus a redirect to the vector,
//   an eret queues a single return cycle, and between scripts the model is
//   either idle or running the handler. All DUT outputs are compared every
//   cycle on the falling edge.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_exception_controller;

  localparam int PC_W         = 10;
  localparam int VEC_BASE     = 'h3C0;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 8;
  localparam int PC_MOD       = 1 << PC_W;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [1:0]       exp_error;
  logic [PC_W-1:0]  mem_pc;
  logic             eret;
  logic             flush;
  logic             redirect_en;
  logic [PC_W-1:0]  redirect_pc;
  logic             in_handler;
  logic             halted;
  logic [1:0]       cause;
  logic [PC_W-1:0]  epc;
  logic [CNT_W-1:0] exp_count;

  exception_controller #(
    .PC_W(PC_W),
    .VEC_BASE(PC_W'(VEC_BASE)),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .exp_error(exp_error),
    .mem_pc(mem_pc),
    .eret(eret),
    .flush(flush),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .in_handler(in_handler),
    .halted(halted),
    .cause(cause),
    .epc(epc),
    .exp_count(exp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // One scripted output cycle.
  typedef struct {
    bit flush;
    bit redirect;
    int rpc;
  } cycle_t;

  cycle_t script[$];
  bit     scripted;
  bit     restInHandler;
  bit     mFlush, mRedirect, mInHandler, mHalted;
  int     mRpc, mCause, mEpc, mCount;

  // Loads the outputs of the next scripted cycle.
  task automatic takeScripted();
    cycle_t c;
    c          = script.pop_front();
    mFlush     = c.flush;
    mRedirect  = c.redirect;
    mRpc       = c.rpc;
    mInHandler = 1'b0;
    scripted   = 1'b1;
  endtask

  // Advances the reference model by one rising edge with the given inputs.
  task automatic modelStep(input bit r, input int e, input int p, input bit er);
    cycle_t c;
    if (!r) begin
      script.delete();
      scripted = 0; restInHandler = 0;
      mFlush = 0; mRedirect = 0; mRpc = 0; mInHandler = 0; mHalted = 0;
      mCause = 0; mEpc = 0; mCount = 0;
    end else if (mHalted) begin
      // Stopped: only reset gets out.
    end else if (scripted) begin
      if (script.size() > 0) begin
        takeScripted();
      end else begin
        scripted   = 0;
        mFlush     = 0;
        mRedirect  = 0;
        mRpc       = 0;
        mInHandler = restInHandler;
      end
    end else if (!restInHandler) begin
      if (e != 0) begin
        mCause = e;
        mEpc   = p;
        if (mCount < CNT_MAX) mCount++;
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
          c.flush = 1; c.redirect = 0; c.rpc = 0;
          script.push_back(c);
        end
        c.flush = 0; c.redirect = 1; c.rpc = (VEC_BASE + mCause * 4) % PC_MOD;
        script.push_back(c);
        restInHandler = 1;
        takeScripted();
      end
    end else begin
      if (e != 0) begin
        if (mCount < CNT_MAX) mCount++;
        mHalted    = 1;
        mFlush     = 1;
        mRedirect  = 0;
        mInHandler = 0;
      end else if (er) begin
        c.flush = 1; c.redirect = 1; c.rpc = (mEpc + 1) % PC_MOD;
        script.push_back(c);
        restInHandler = 0;
        takeScripted();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic checkOutput();
    chk("flush", 32'(flush), 32'(mFlush));
    chk("redirect_en", 32'(redirect_en), 32'(mRedirect));
    if (mRedirect) chk("redirect_pc", 32'(redirect_pc), 32'(mRpc));
    chk("in_handler", 32'(in_handler), 32'(mInHandler));
    chk("halted", 32'(halted), 32'(mHalted));
    chk("cause", 32'(cause), 32'(mCause));
    chk("epc", 32'(epc), 32'(mEpc));
    chk("exp_count", 32'(exp_count), 32'(mCount));
  endtask

  // Drives one cycle of inputs, steps the model at the edge, checks on negedge.
  task automatic applyStimulus(input bit r, input int e, input int p, input bit er);
    reset     = r;
    exp_error = 2'(e);
    mem_pc    = PC_W'(p);
    eret      = er;
    @(posedge clk);
    modelStep(r, e, p, er);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0);
  endtask

  // Raises an exception and runs until the handler is active.
  task automatic enterHandler(input int e, input int p);
    applyStimulus(1, e, p, 0);
    idle(FLUSH_CYCLES + 1);
  endtask

  initial begin
    reset = 1'b0; exp_error = 2'b00; mem_pc = '0; eret = 1'b0;
    script.delete();
    scripted = 0; restInHandler = 0;
    mFlush = 0; mRedirect = 0; mRpc = 0; mInHandler = 0; mHalted = 0;
    mCause = 0; mEpc = 0; mCount = 0;
    @(negedge clk);

    // Reset, then quiet idle with a stray eret that must be ignored.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    idle(4);
    applyStimulus(1, 0, 'h123, 1);
    idle(5);

    // Illegal-op exception, then a double fault with concurrent eret.
    enterHandler(2, 'h045);
    idle(2);
    applyStimulus(1, 3, 'h200, 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, $urandom_range(0, 3), $urandom, $urandom_range(0, 1));

    // Reset out of HALTED, then a clean exception and return.
    applyStimulus(0, 0, 0, 0);
    idle(2);
    enterHandler(2, 'h045);
    applyStimulus(1, 0, 0, 1);
    idle(3);

    // Overflow at the top of the address space; codes during flush are masked.
    applyStimulus(1, 1, 'h3FF, 0);
    for (int i = 0; i < FLUSH_CYCLES; i++) applyStimulus(1, 3, 'h111, 0);
    applyStimulus(1, 3, 'h112, 1);
    idle(1);
    applyStimulus(1, 0, 0, 1);
    idle(2);

    // Saturation of the exception counter.
    applyStimulus(0, 0, 0, 0);
    for (int n = 0; n < CNT_MAX + 1; n++) begin
      enterHandler($urandom_range(1, 3), $urandom_range(0, PC_MOD - 1));
      applyStimulus(1, 0, 0, 1);
      idle(1);
    end

    // Reset in the middle of a flush.
    applyStimulus(1, 2, 'h0AA, 0);
    applyStimulus(0, 0, 0, 0);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 39) != 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                    $urandom_range(0, PC_MOD - 1),
                    $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
